// File: rtl/instr_fetch_seq_pkg.sv
// Shared processor types: fetch FSM states, instruction width, opcode mnemonics.
package proc_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        EXEC   = 2'd2,
        HALTED = 2'd3
    } fetch_state_t;

    localparam int unsigned INSTR_W = 9;
    localparam logic [3:0]  OP_HALT = 4'b1110;

    typedef enum logic [3:0] {
        MN_ADD = 4'b0000,
        MN_SUB = 4'b0001,
        MN_AND = 4'b0010,
        MN_OR  = 4'b0011,
        MN_XOR = 4'b0100,
        MN_NOT = 4'b0101,
        MN_SHL = 4'b0110,
        MN_SHR = 4'b0111,
        MN_LD  = 4'b1000,
        MN_ST  = 4'b1001,
        MN_MOV = 4'b1010,
        MN_CMP = 4'b1011,
        MN_JMP = 4'b1100,
        MN_JZ  = 4'b1101,
        MN_HLT = 4'b1110,
        MN_NOP = 4'b1111
    } op_mne;

endpackage

// File: rtl/instr_fetch_seq_if.sv
// Sequencer bus: start/done handshake, instruction memory, branch/stall and decoded fields.
// INSTR_COUNT_EN adds the INSTR_COUNT signal.
interface instr_fetch_seq_if #(
    parameter int PC_W = 10,
    parameter int IW   = 9
);
    logic            START;
    logic [PC_W-1:0] IMEM_ADDR;
    logic [IW-1:0]   IMEM_DATA;
    logic            STALL;
    logic            BRANCH_TAKEN;
    logic [PC_W-1:0] BRANCH_TARGET;
    logic            INSTR_VALID;
    logic            TYPE_BIT;
    logic [3:0]      OP;
    logic [3:0]      REG_SEL;
    logic [PC_W-1:0] PC;
    logic            DONE;
`ifdef INSTR_COUNT_EN
    logic [15:0]     INSTR_COUNT;
`endif

    modport master (
        input  START, IMEM_DATA, STALL, BRANCH_TAKEN, BRANCH_TARGET,
        output IMEM_ADDR, INSTR_VALID, TYPE_BIT, OP, REG_SEL, PC, DONE
`ifdef INSTR_COUNT_EN
        , output INSTR_COUNT
`endif
    );

    modport slave (
        output START, IMEM_DATA, STALL, BRANCH_TAKEN, BRANCH_TARGET,
        input  IMEM_ADDR, INSTR_VALID, TYPE_BIT, OP, REG_SEL, PC, DONE
`ifdef INSTR_COUNT_EN
        , input INSTR_COUNT
`endif
    );

endinterface

// File: rtl/instr_fetch_seq_decode.sv
// Combinational split of the instruction register into ALU fields plus halt detect.
module instr_decode
    import proc_pkg::*;
(
    input  logic [INSTR_W-1:0] ir,
    output logic               type_bit,
    output logic [3:0]         op,
    output logic [3:0]         reg_sel,
    output logic               is_halt
);

    assign type_bit = ir[8];
    assign op       = ir[7:4];
    assign reg_sel  = ir[3:0];
    // Halt only for type 0; type 1 with the same opcode is an ordinary instruction.
    assign is_halt  = !ir[8] && (ir[7:4] == OP_HALT);

endmodule

// File: rtl/instr_fetch_seq.sv
// Program sequencer: owns PC, fetches into IR, drives decoded fields to the ALU.
// INSTR_COUNT_EN enables a saturating count of completed EXEC cycles.
module instr_fetch_seq
    import proc_pkg::*;
#(
    parameter int PC_W = 10,
    parameter int IW   = 9
) (
    input  logic           CLK,
    input  logic           RST_N,
    instr_fetch_seq_if.master bus
);

    fetch_state_t    state, state_next;
    logic [PC_W-1:0] pc;
    logic [IW-1:0]   ir;
    logic            is_halt;
    logic            instr_valid;
    logic            done;
    logic            start_ok;

    assign start_ok = bus.START && ((state == IDLE) || (state == HALTED));

    always_ff @(posedge CLK) begin
        if (!RST_N) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.START) state_next = FETCH;
            FETCH:   state_next = EXEC;
            EXEC: begin
                if (!bus.STALL) state_next = is_halt ? HALTED : FETCH;
            end
            HALTED:  if (bus.START) state_next = FETCH;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        instr_valid = 1'b0;
        done        = 1'b0;
        case (state)
            EXEC:    instr_valid = 1'b1;
            HALTED:  done        = 1'b1;
            default: ;
        endcase
    end

    // Stall outranks halt, which outranks branch.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            pc <= '0;
            ir <= '0;
        end else begin
            case (state)
                IDLE, HALTED: if (bus.START) pc <= '0;
                FETCH:        ir <= bus.IMEM_DATA;
                EXEC: begin
                    if (!bus.STALL && !is_halt) begin
                        if (bus.BRANCH_TAKEN) pc <= bus.BRANCH_TARGET;
                        else                  pc <= pc + PC_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    instr_decode u_decode (
        .ir       (ir),
        .type_bit (bus.TYPE_BIT),
        .op       (bus.OP),
        .reg_sel  (bus.REG_SEL),
        .is_halt  (is_halt)
    );

`ifdef INSTR_COUNT_EN
    logic [15:0] instr_count;

    always_ff @(posedge CLK) begin
        if (!RST_N || start_ok) begin
            instr_count <= '0;
        end else if (state == EXEC && !bus.STALL && instr_count != '1) begin
            instr_count <= instr_count + 16'd1;
        end
    end

    assign bus.INSTR_COUNT = instr_count;
`else
    logic unused_start_ok;
    assign unused_start_ok = start_ok;
`endif

    assign bus.IMEM_ADDR   = pc;
    assign bus.PC          = pc;
    assign bus.INSTR_VALID = instr_valid;
    assign bus.DONE        = done;

endmodule

// File: doc/instr_fetch_seq.md
Name: instr_fetch_seq

Overview:
- Program sequencer directly upstream of the ALU in the 8-bit accumulator processor.
- Owns the program counter and drives the instruction-memory address.
- Captures the 9-bit instruction and splits it into the fields the ALU consumes: TYPE_BIT, OP, REG_SEL.
- Handles start/halt handshake with the testbench, branch redirect and execute stalls.

Parameters:
- PC_W, 10, program-counter / instruction-address width
- IW, 9, instruction width: {type_bit, op[3:0], operand[3:0]}

Ports:
- CLK  input  1  system clock, all state on rising edge
- RST_N  input  1  synchronous, active-low reset
- START  input  1  pulse; begins execution at address 0
- IMEM_ADDR  output  PC_W  instruction-memory address (combinational-read ROM)
- IMEM_DATA  input  IW  instruction word at IMEM_ADDR, same cycle
- STALL  input  1  holds current instruction in EXEC (multicycle load/store)
- BRANCH_TAKEN  input  1  sampled in EXEC; redirects PC
- BRANCH_TARGET  input  PC_W  absolute branch destination
- INSTR_VALID  output  1  decoded fields valid this cycle (EXEC state)
- TYPE_BIT  output  1  IR[8]
- OP  output  4  IR[7:4]
- REG_SEL  output  4  IR[3:0]
- PC  output  PC_W  address of instruction in IR
- DONE  output  1  high while HALTED

Behaviour:
- Reset (RST_N=0 at edge): state=IDLE, PC=0, IR=0, INSTR_VALID=0, DONE=0, IMEM_ADDR=0. Reset wins over every other input, including mid-EXEC and mid-STALL.
- States:
  - IDLE: wait for START. On START: PC<=0, go to FETCH.
  - FETCH: IMEM_ADDR=PC. IR<=IMEM_DATA. Go to EXEC. INSTR_VALID=0.
  - EXEC: INSTR_VALID=1; fields come from IR. Exit is resolved in this order:
    1. If STALL=1: remain in EXEC with PC and IR held. BRANCH_TAKEN is ignored while stalled.
    2. Else if IR is halt ({0,4'b1110,xxxx}): go to HALTED, PC unchanged.
    3. Else if BRANCH_TAKEN=1: PC<=BRANCH_TARGET, go to FETCH.
    4. Else PC<=PC+1, go to FETCH.
  - HALTED: DONE=1, INSTR_VALID=0. On START: DONE<=0, PC<=0, go to FETCH (rerun). Otherwise hold.
- START outside IDLE/HALTED is ignored.
- Latency: 2 cycles per unstalled instruction; first INSTR_VALID occurs 2 cycles after the START edge.
- PC increment is modulo 2^PC_W. All-ones wraps to 0 with no flag.
- Halt detection: TYPE_BIT=1 with OP=1110 is a non-halt instruction. Halt takes precedence over a simultaneous BRANCH_TAKEN.
- IMEM_ADDR=PC in every state.
- Outputs are registered or decoded from state/IR only; there is no combinational path from IMEM_DATA to any output.

Optional Feature:
- Macro: INSTR_COUNT_EN.
- Defined:
  - Adds output INSTR_COUNT, 16 bits.
  - Increments on each EXEC cycle with STALL=0, including the halt instruction.
  - Cleared by reset and by START.
  - Saturates at 16'hFFFF.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package proc_pkg contains:
  - enum fetch_state_t {IDLE, FETCH, EXEC, HALTED}
  - constant OP_HALT=4'b1110
  - constant INSTR_W=9
  - the existing op_mne opcode enum shared with the ALU
- Natural sub-module: instr_decode, a purely combinational split of IR into TYPE_BIT/OP/REG_SEL plus an is_halt flag.
- PC/FSM logic stays in instr_fetch_seq.

Test Plan:
- Reset then START. ROM[0]=9'h0_03, ROM[1]=9'h0_E0 (halt). Required:
  - INSTR_VALID at cycles 2 and 4.
  - OP=0000 then OP=1110.
  - DONE=1 at cycle 5, PC=1.
- Branch: ROM[0]=take, BRANCH_TAKEN=1 and BRANCH_TARGET=10'h005 in EXEC. Required: next IMEM_ADDR=5, PC=5 at the following INSTR_VALID.
- Stall: assert STALL for 3 EXEC cycles at PC=2, with BRANCH_TAKEN=1 during the stall. Required:
  - INSTR_VALID held for 4 cycles.
  - PC stays 2, then goes to 3 (the branch is ignored).
  - INSTR_COUNT (if enabled) increments once.
- Wrap: preload via branch to 10'h3FF with a non-halt instruction. Required: next PC=0.
- Reset mid-operation: RST_N=0 during EXEC with STALL=1. Required: IDLE next cycle, PC=0, INSTR_VALID=0, DONE=0. START then restarts from 0.
- TYPE_BIT=1, OP=1110 (9'h1E0) is not a halt. Required: PC increments and DONE stays 0. A HALTED→START rerun clears DONE and refetches address 0.
